// File: rtl/tcam_pkg.sv
// Shared types and constants for the TCAM row update sequencer.
// Optional build macro used by the top: TCAM_LKP_STARVE_GUARD_EN.
package tcam_pkg;

    localparam int NUM_RULES = 120;
    localparam int KEY_W     = 8;
    localparam int IDX_W     = 7;
    localparam int MAX_STALL = 4;
    localparam int STALL_W   = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Match bit stored at one key address of a rule column: the address
    // matches when it agrees with the value on every cared-for bit.
    // A delete always writes zero.
    function automatic logic ternary_bit(
        input logic [KEY_W-1:0] addr,
        input logic [KEY_W-1:0] value,
        input logic [KEY_W-1:0] mask,
        input logic             del
    );
        return !del && ((addr & ~mask) == (value & ~mask));
    endfunction

endpackage

// File: rtl/tcam_col_decode.sv
// Rule index to one-hot column-enable decoder. Indices beyond the last
// rule column decode to all zeros, so they can never enable a write.
module tcam_col_decode
    import tcam_pkg::*;
(
    input  logic [IDX_W-1:0]     idx,
    output logic [NUM_RULES-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RULES; gi++) begin : g_col
            assign onehot[gi] = (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/tcam_update_ctrl.sv
// Update sequencer and port arbiter for the RAM-based TCAM row.
// A rule update becomes a 256-address write sweep of its match column;
// lookups share the same single access port and win arbitration.
// Build macro TCAM_LKP_STARVE_GUARD_EN: when defined, a run of MAX_STALL
// lost sweep cycles forces one write cycle; when undefined, lookups have
// strict priority and may stall a sweep indefinitely.
module tcam_update_ctrl
    import tcam_pkg::*;
(
    input  logic                 write_clk,
    input  logic                 rst_n,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic [KEY_W-1:0]     upd_value,
    input  logic [KEY_W-1:0]     upd_mask,
    input  logic                 upd_del,
    output logic                 upd_done,
    output logic                 upd_err,
    input  logic                 lkp_valid,
    output logic                 lkp_ready,
    input  logic [KEY_W-1:0]     lkp_key,
    output logic                 ram_wren,
    output logic                 ram_readen,
    output logic [KEY_W-1:0]     ram_wr_addr,
    output logic [KEY_W-1:0]     ram_key,
    output logic [NUM_RULES-1:0] ram_col_sel,
    output logic                 ram_wr_bit,
    output logic                 busy,
    output logic [NUM_RULES-1:0] rule_valid
);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg;
    logic [KEY_W-1:0]     value_reg, mask_reg, cnt_reg;
    logic                 del_reg;
    logic [NUM_RULES-1:0] col_onehot;
    logic                 upd_ready_reg, upd_done_reg, upd_err_reg;
    logic                 ram_wren_reg, ram_readen_reg, ram_wr_bit_reg;
    logic [KEY_W-1:0]     ram_wr_addr_reg, ram_key_reg;
    logic [NUM_RULES-1:0] ram_col_sel_reg, rule_valid_reg;
    logic                 upd_accept, upd_in_range, lkp_grant, upd_grant;
    logic                 force_upd;

    tcam_col_decode u_col_decode (
        .idx    (idx_reg),
        .onehot (col_onehot)
    );

`ifdef TCAM_LKP_STARVE_GUARD_EN
    logic [STALL_W-1:0] stall_reg;

    assign force_upd = (state_reg == SWEEP) && (stall_reg == STALL_W'(MAX_STALL));

    // Count consecutive sweep cycles lost to lookups; any write clears it.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if ((state_reg == SWEEP) && lkp_grant) begin
            stall_reg <= stall_reg + STALL_W'(1);
        end else begin
            stall_reg <= '0;
        end
    end
`else
    assign force_upd = 1'b0;
`endif

    // State register.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a sweep ends on the grant of the last address.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (upd_accept && upd_in_range) state_next = SWEEP;
            SWEEP:   if (upd_grant && (cnt_reg == {KEY_W{1'b1}})) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arbitration and handshake decode; lookups win unless a write is forced.
    always_comb begin
        lkp_grant    = lkp_valid && !force_upd;
        upd_grant    = (state_reg == SWEEP) && !lkp_grant;
        upd_accept   = (state_reg == IDLE) && upd_valid && upd_ready_reg;
        upd_in_range = (upd_idx < IDX_W'(NUM_RULES));
    end

    // Latch the accepted rule and step the sweep address on each write grant.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            value_reg <= '0;
            mask_reg  <= '0;
            del_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else if (upd_accept && upd_in_range) begin
            idx_reg   <= upd_idx;
            value_reg <= upd_value;
            mask_reg  <= upd_mask;
            del_reg   <= upd_del;
            cnt_reg   <= '0;
        end else if (upd_grant) begin
            cnt_reg <= cnt_reg + KEY_W'(1);
        end
    end

    // Registered row-port strobes; write-side fields are zero when idle.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wren_reg    <= 1'b0;
            ram_wr_addr_reg <= '0;
            ram_col_sel_reg <= '0;
            ram_wr_bit_reg  <= 1'b0;
            ram_readen_reg  <= 1'b0;
            ram_key_reg     <= '0;
        end else begin
            ram_wren_reg    <= upd_grant;
            ram_wr_addr_reg <= upd_grant ? cnt_reg : '0;
            ram_col_sel_reg <= upd_grant ? col_onehot : '0;
            ram_wr_bit_reg  <= upd_grant && ternary_bit(cnt_reg, value_reg, mask_reg, del_reg);
            ram_readen_reg  <= lkp_grant;
            ram_key_reg     <= lkp_grant ? lkp_key : '0;
        end
    end

    // Handshake pulses, ready flag and rule-valid bookkeeping.
    // upd_ready is registered so that it reads zero while in reset.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_ready_reg  <= 1'b0;
            upd_done_reg   <= 1'b0;
            upd_err_reg    <= 1'b0;
            rule_valid_reg <= '0;
        end else begin
            upd_ready_reg <= (state_next == IDLE);
            upd_done_reg  <= (state_reg == DONE);
            upd_err_reg   <= upd_accept && !upd_in_range;
            if (state_reg == DONE) begin
                rule_valid_reg <= del_reg ? (rule_valid_reg & ~col_onehot)
                                          : (rule_valid_reg | col_onehot);
            end
        end
    end

    assign upd_ready   = upd_ready_reg;
    assign upd_done    = upd_done_reg;
    assign upd_err     = upd_err_reg;
    assign lkp_ready   = !force_upd;
    assign ram_wren    = ram_wren_reg;
    assign ram_readen  = ram_readen_reg;
    assign ram_wr_addr = ram_wr_addr_reg;
    assign ram_key     = ram_key_reg;
    assign ram_col_sel = ram_col_sel_reg;
    assign ram_wr_bit  = ram_wr_bit_reg;
    assign busy        = (state_reg != IDLE);
    assign rule_valid  = rule_valid_reg;

endmodule
